// File: rtl/matrix_keypad_scanner.sv
// Matrix keypad scanner: ROWS x COLS, with a 2-flop row synchroniser,
// multi-scan debounce, multi-key (ghost) rejection, optional typematic
// auto-repeat and a valid/ready code output.
module matrix_keypad_scanner #(
  parameter int ROWS        = 4,
  parameter int COLS        = 4,
  parameter int DEBOUNCE    = 2,
  parameter int REPEAT_DLY  = 0,
  parameter int REPEAT_RATE = 4,
  parameter int CODE_W      = $clog2(ROWS * COLS)
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [ROWS-1:0]   row_in,
  output logic [COLS-1:0]   col_out,
  output logic [CODE_W-1:0] key_code,
  output logic              key_valid,
  input  logic              key_ready,
  output logic              key_held,
  output logic              multi_key,
  output logic              overrun
);

  localparam int CW = (COLS > 1) ? $clog2(COLS) : 1;
  localparam int DW = (DEBOUNCE > 0) ? $clog2(DEBOUNCE + 1) : 1;
  localparam int RW = $clog2(REPEAT_DLY + REPEAT_RATE + 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SCAN = 2'd1,
    ST_HELD = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [ROWS-1:0]   sync1_q, sync1_d;
  logic [ROWS-1:0]   sync2_q, sync2_d;
  logic [CW-1:0]     col_idx_q, col_idx_d;
  logic [1:0]        dwell_q, dwell_d;
  logic [1:0]        hit_cnt_q, hit_cnt_d;
  logic [CODE_W-1:0] first_code_q, first_code_d;
  logic [CODE_W-1:0] cand_q, cand_d;
  logic [DW-1:0]     db_cnt_q, db_cnt_d;
  logic [DW-1:0]     rel_cnt_q, rel_cnt_d;
  logic [RW-1:0]     rep_cnt_q, rep_cnt_d;
  logic [COLS-1:0]   col_out_q, col_out_d;
  logic [CODE_W-1:0] key_code_q, key_code_d;
  logic              key_valid_q, key_valid_d;
  logic              key_held_q, key_held_d;
  logic              multi_key_q, multi_key_d;
  logic              overrun_q, overrun_d;

  // Scan-engine combinational helpers
  logic [ROWS-1:0]   s_row;
  logic              sample_s;
  logic              last_col_s;
  logic [1:0]        col_cnt_s;
  logic [CODE_W-1:0] col_code_s;
  logic [1:0]        tot_cnt_s;
  logic [CODE_W-1:0] tot_code_s;
  logic              scan_end_s;

  // FSM helpers
  logic              emit_s;
  logic [CODE_W-1:0] emit_code_s;
  logic [DW-1:0]     db_new_s;
  logic [DW-1:0]     rel_new_s;
  logic [RW-1:0]     rep_new_s;
  logic              accept_s;

  assign s_row = sync2_q;

  // Two-flop synchroniser feed for the asynchronous row inputs
  always_comb begin
    sync1_d = row_in;
    sync2_d = sync1_q;
  end

  // Per-column hit count (saturating at 2) and code of the lowest closed row
  always_comb begin
    col_cnt_s  = 2'd0;
    col_code_s = '0;
    for (int r = ROWS - 1; r >= 0; r--) begin
      if (s_row[r]) begin
        col_code_s = CODE_W'(r * COLS) + CODE_W'(col_idx_q);
        if (col_cnt_s != 2'd2) begin
          col_cnt_s = col_cnt_s + 2'd1;
        end else begin
          col_cnt_s = col_cnt_s;
        end
      end else begin
        col_code_s = col_code_s;
      end
    end
  end

  // Accumulate the scan result: running count (0/1/2+) and first hit code
  always_comb begin
    sample_s   = (dwell_q == 2'd2);
    last_col_s = (col_idx_q == CW'(COLS - 1));
    if ((hit_cnt_q == 2'd2) || (col_cnt_s == 2'd2) ||
        ((hit_cnt_q == 2'd1) && (col_cnt_s == 2'd1))) begin
      tot_cnt_s = 2'd2;
    end else begin
      tot_cnt_s = hit_cnt_q | col_cnt_s;
    end
    if (hit_cnt_q == 2'd0) begin
      tot_code_s = col_code_s;
    end else begin
      tot_code_s = first_code_q;
    end
  end

  // Column walk: 3-cycle dwell per column, sample on the 3rd, wrap after the last
  always_comb begin
    col_idx_d    = col_idx_q;
    dwell_d      = dwell_q;
    hit_cnt_d    = hit_cnt_q;
    first_code_d = first_code_q;
    scan_end_s   = 1'b0;
    if (state_q == ST_IDLE) begin
      col_idx_d = '0;
      dwell_d   = 2'd0;
      hit_cnt_d = 2'd0;
    end else if (sample_s) begin
      dwell_d = 2'd0;
      if (last_col_s) begin
        col_idx_d  = '0;
        hit_cnt_d  = 2'd0;
        scan_end_s = 1'b1;
      end else begin
        col_idx_d    = col_idx_q + CW'(1);
        hit_cnt_d    = tot_cnt_s;
        first_code_d = tot_code_s;
      end
    end else begin
      dwell_d = dwell_q + 2'd1;
    end
  end

  // Main FSM: debounce press, track held key, auto-repeat, debounce release
  always_comb begin
    state_d     = state_q;
    cand_d      = cand_q;
    db_cnt_d    = db_cnt_q;
    rel_cnt_d   = rel_cnt_q;
    rep_cnt_d   = rep_cnt_q;
    key_held_d  = key_held_q;
    multi_key_d = multi_key_q;
    emit_s      = 1'b0;
    emit_code_s = cand_q;
    db_new_s    = '0;
    rel_new_s   = rel_cnt_q + DW'(1);
    rep_new_s   = rep_cnt_q + RW'(1);

    if (scan_end_s) begin
      multi_key_d = (tot_cnt_s == 2'd2);
    end else begin
      multi_key_d = multi_key_q;
    end

    case (state_q)
      ST_IDLE: begin
        if (s_row != '0) begin
          state_d  = ST_SCAN;
          db_cnt_d = '0;
        end else begin
          state_d = ST_IDLE;
        end
      end

      ST_SCAN: begin
        if (scan_end_s) begin
          if (tot_cnt_s == 2'd0) begin
            state_d = ST_IDLE;
          end else if (tot_cnt_s == 2'd2) begin
            db_cnt_d = '0;
          end else begin
            if (tot_code_s == cand_q) begin
              db_new_s = db_cnt_q + DW'(1);
            end else begin
              cand_d   = tot_code_s;
              db_new_s = DW'(1);
            end
            db_cnt_d = db_new_s;
            if (db_new_s >= DW'(DEBOUNCE)) begin
              emit_s      = 1'b1;
              emit_code_s = cand_d;
              key_held_d  = 1'b1;
              rep_cnt_d   = '0;
              rel_cnt_d   = '0;
              db_cnt_d    = '0;
              state_d     = ST_HELD;
            end else begin
              state_d = ST_SCAN;
            end
          end
        end else begin
          state_d = ST_SCAN;
        end
      end

      ST_HELD: begin
        if (scan_end_s) begin
          if ((tot_cnt_s == 2'd1) && (tot_code_s == cand_q)) begin
            rel_cnt_d = '0;
            rep_cnt_d = rep_new_s;
            if (REPEAT_DLY > 0) begin
              if (rep_new_s == RW'(REPEAT_DLY)) begin
                emit_s = 1'b1;
              end else if (rep_new_s == RW'(REPEAT_DLY + REPEAT_RATE)) begin
                // Fold back so the repeat period keeps cycling without overflow
                emit_s    = 1'b1;
                rep_cnt_d = RW'(REPEAT_DLY);
              end else begin
                emit_s = 1'b0;
              end
            end else begin
              emit_s = 1'b0;
            end
          end else begin
            if (rel_new_s >= DW'(DEBOUNCE)) begin
              rel_cnt_d  = '0;
              key_held_d = 1'b0;
              state_d    = ST_IDLE;
            end else begin
              rel_cnt_d = rel_new_s;
            end
          end
        end else begin
          state_d = ST_HELD;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Output handshake: load on emit unless a code is pending and not being taken
  always_comb begin
    key_code_d  = key_code_q;
    key_valid_d = key_valid_q;
    overrun_d   = 1'b0;
    accept_s    = key_valid_q & key_ready;
    if (emit_s) begin
      if (!key_valid_q || accept_s) begin
        key_code_d  = emit_code_s;
        key_valid_d = 1'b1;
      end else begin
        overrun_d = 1'b1;
      end
    end else if (accept_s) begin
      key_valid_d = 1'b0;
    end else begin
      key_valid_d = key_valid_q;
    end
  end

  // Column drive follows the next state so it lines up with the dwell counter
  always_comb begin
    if (state_d == ST_IDLE) begin
      col_out_d = '1;
    end else begin
      col_out_d = {{(COLS - 1){1'b0}}, 1'b1} << col_idx_d;
    end
  end

  // State and datapath registers
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q      <= ST_IDLE;
      sync1_q      <= '0;
      sync2_q      <= '0;
      col_idx_q    <= '0;
      dwell_q      <= 2'd0;
      hit_cnt_q    <= 2'd0;
      first_code_q <= '0;
      cand_q       <= '0;
      db_cnt_q     <= '0;
      rel_cnt_q    <= '0;
      rep_cnt_q    <= '0;
      col_out_q    <= '1;
      key_code_q   <= '0;
      key_valid_q  <= 1'b0;
      key_held_q   <= 1'b0;
      multi_key_q  <= 1'b0;
      overrun_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      sync1_q      <= sync1_d;
      sync2_q      <= sync2_d;
      col_idx_q    <= col_idx_d;
      dwell_q      <= dwell_d;
      hit_cnt_q    <= hit_cnt_d;
      first_code_q <= first_code_d;
      cand_q       <= cand_d;
      db_cnt_q     <= db_cnt_d;
      rel_cnt_q    <= rel_cnt_d;
      rep_cnt_q    <= rep_cnt_d;
      col_out_q    <= col_out_d;
      key_code_q   <= key_code_d;
      key_valid_q  <= key_valid_d;
      key_held_q   <= key_held_d;
      multi_key_q  <= multi_key_d;
      overrun_q    <= overrun_d;
    end
  end

  assign col_out   = col_out_q;
  assign key_code  = key_code_q;
  assign key_valid = key_valid_q;
  assign key_held  = key_held_q;
  assign multi_key = multi_key_q;
  assign overrun   = overrun_q;

endmodule

// File: tb/tb_matrix_keypad_scanner.sv
// Directed bench for matrix_keypad_scanner: two instances (repeat off / on)
// each driven by a behavioural 4x4 keypad model.
module tb_matrix_keypad_scanner;

  logic        clk;
  logic        rst_n;
  logic [15:0] keys0, keys1;
  logic [3:0]  row0, row1;
  logic [3:0]  col0, col1;
  logic [3:0]  kc0, kc1;
  logic        kv0, kv1, kr0, kr1;
  logic        kh0, kh1, mk0, mk1, ov0, ov1;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int ovr0     = 0;
  int codes0[$];
  int codes1[$];
  int stamp1[$];

  matrix_keypad_scanner dut0 (
    .clock(clk), .reset(rst_n), .row_in(row0), .col_out(col0),
    .key_code(kc0), .key_valid(kv0), .key_ready(kr0),
    .key_held(kh0), .multi_key(mk0), .overrun(ov0)
  );

  matrix_keypad_scanner #(.REPEAT_DLY(3), .REPEAT_RATE(2)) dut1 (
    .clock(clk), .reset(rst_n), .row_in(row1), .col_out(col1),
    .key_code(kc1), .key_valid(kv1), .key_ready(kr1),
    .key_held(kh1), .multi_key(mk1), .overrun(ov1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Keypad model: a row reads 1 when a closed key sits on a driven column
  always_comb begin
    for (int r = 0; r < 4; r++) begin
      row0[r] = |(keys0[r*4 +: 4] & col0);
      row1[r] = |(keys1[r*4 +: 4] & col1);
    end
  end

  always @(posedge clk) cyc <= cyc + 1;

  // Record every accepted code and every overrun pulse
  always @(negedge clk) begin
    if (kv0 && kr0) codes0.push_back(int'(kc0));
    if (ov0) ovr0 <= ovr0 + 1;
    if (kv1 && kr1) begin
      codes1.push_back(int'(kc1));
      stamp1.push_back(cyc);
    end
  end

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic test_reset();
    rst_n = 1'b0; keys0 = 16'h0; keys1 = 16'h0; kr0 = 1'b1; kr1 = 1'b1;
    wait_cyc(2);
    n_checks++; if (col0 !== 4'hF) begin n_fail++; $display("FAIL reset_col0 got %h exp f", col0); end
    n_checks++; if (col1 !== 4'hF) begin n_fail++; $display("FAIL reset_col1 got %h exp f", col1); end
    n_checks++; if ({kc0, kv0, kh0, mk0, ov0} !== 8'h00) begin n_fail++;
      $display("FAIL reset_outs got code=%0d v=%b h=%b m=%b o=%b exp all 0", kc0, kv0, kh0, mk0, ov0); end
    rst_n = 1'b1;
    wait_cyc(5);
    n_checks++; if (col0 !== 4'hF) begin n_fail++; $display("FAIL idle_col0 got %h exp f", col0); end
  endtask

  task automatic test_each_key();
    int base;
    for (int j = 0; j < 16; j++) begin
      base = codes0.size();
      keys0 = 16'h1 << j;
      wait_cyc(300);
      n_checks++; if (kh0 !== 1'b1) begin n_fail++; $display("FAIL key%0d_held got %b exp 1", j, kh0); end
      keys0 = 16'h0;
      wait_cyc(100);
      n_checks++; if (kh0 !== 1'b0) begin n_fail++; $display("FAIL key%0d_release got %b exp 0", j, kh0); end
      n_checks++; if (codes0.size() - base !== 1) begin n_fail++;
        $display("FAIL key%0d_count got %0d exp 1", j, codes0.size() - base); end
      else begin
        n_checks++; if (codes0[base] !== j) begin n_fail++;
          $display("FAIL key%0d_code got %0d exp %0d", j, codes0[base], j); end
      end
    end
  endtask

  task automatic test_bounce();
    int base;
    base = codes0.size();
    for (int i = 0; i < 10; i++) begin
      keys0 = (i % 2 == 0) ? 16'h0020 : 16'h0000;
      wait_cyc(1);
    end
    keys0 = 16'h0020;
    wait_cyc(300);
    keys0 = 16'h0;
    wait_cyc(100);
    n_checks++; if (codes0.size() - base !== 1) begin n_fail++;
      $display("FAIL bounce_count got %0d exp 1", codes0.size() - base); end
    else begin
      n_checks++; if (codes0[base] !== 5) begin n_fail++; $display("FAIL bounce_code got %0d exp 5", codes0[base]); end
    end
  endtask

  task automatic test_multi_key();
    int base;
    base = codes0.size();
    keys0 = 16'h0084;
    wait_cyc(200);
    n_checks++; if (mk0 !== 1'b1) begin n_fail++; $display("FAIL multi_flag got %b exp 1", mk0); end
    n_checks++; if (kv0 !== 1'b0) begin n_fail++; $display("FAIL multi_valid got %b exp 0", kv0); end
    n_checks++; if (codes0.size() - base !== 0) begin n_fail++;
      $display("FAIL multi_nocode got %0d exp 0", codes0.size() - base); end
    keys0 = 16'h0004;
    wait_cyc(200);
    n_checks++; if (mk0 !== 1'b0) begin n_fail++; $display("FAIL multi_clear got %b exp 0", mk0); end
    n_checks++; if (codes0.size() - base !== 1) begin n_fail++;
      $display("FAIL multi_count got %0d exp 1", codes0.size() - base); end
    else begin
      n_checks++; if (codes0[base] !== 2) begin n_fail++; $display("FAIL multi_code got %0d exp 2", codes0[base]); end
    end
    keys0 = 16'h0;
    wait_cyc(100);
  endtask

  task automatic test_repeat();
    int base;
    int got;
    int exp_gap[5] = '{36, 24, 24, 24, 24};
    base = codes1.size();
    got = 0;
    keys1 = 16'h0400;
    for (int i = 0; i < 200 && got == 0; i++) begin
      wait_cyc(1);
      if (codes1.size() > base) got = 1;
    end
    n_checks++; if (got !== 1) begin n_fail++; $display("FAIL repeat_first timeout got none exp code 10"); end
    wait_cyc(138);
    keys1 = 16'h0;
    wait_cyc(100);
    n_checks++; if (codes1.size() - base !== 6) begin n_fail++;
      $display("FAIL repeat_count got %0d exp 6", codes1.size() - base); end
    else begin
      for (int k = 0; k < 6; k++) begin
        n_checks++; if (codes1[base + k] !== 10) begin n_fail++;
          $display("FAIL repeat_code%0d got %0d exp 10", k, codes1[base + k]); end
      end
      for (int k = 0; k < 5; k++) begin
        n_checks++; if (stamp1[base + k + 1] - stamp1[base + k] !== exp_gap[k]) begin n_fail++;
          $display("FAIL repeat_gap%0d got %0d exp %0d", k, stamp1[base + k + 1] - stamp1[base + k], exp_gap[k]); end
      end
    end
    n_checks++; if (kh1 !== 1'b0) begin n_fail++; $display("FAIL repeat_release got %b exp 0", kh1); end
  endtask

  task automatic test_overrun();
    int base;
    int ob;
    base = codes0.size();
    ob = ovr0;
    kr0 = 1'b0;
    keys0 = 16'h0008; wait_cyc(100);
    keys0 = 16'h0;    wait_cyc(100);
    keys0 = 16'h0200; wait_cyc(100);
    keys0 = 16'h0;    wait_cyc(100);
    n_checks++; if (kv0 !== 1'b1) begin n_fail++; $display("FAIL ovr_valid got %b exp 1", kv0); end
    n_checks++; if (kc0 !== 4'd3) begin n_fail++; $display("FAIL ovr_code got %0d exp 3", kc0); end
    n_checks++; if (ovr0 - ob !== 1) begin n_fail++; $display("FAIL ovr_pulses got %0d exp 1", ovr0 - ob); end
    kr0 = 1'b1;
    wait_cyc(2);
    n_checks++; if (kv0 !== 1'b0) begin n_fail++; $display("FAIL ovr_drain got %b exp 0", kv0); end
    n_checks++; if (codes0.size() - base !== 1) begin n_fail++;
      $display("FAIL ovr_count got %0d exp 1", codes0.size() - base); end
    else begin
      n_checks++; if (codes0[base] !== 3) begin n_fail++; $display("FAIL ovr_taken got %0d exp 3", codes0[base]); end
    end
  endtask

  task automatic test_mid_reset();
    int base;
    kr0 = 1'b0;
    keys0 = 16'h0040;
    wait_cyc(100);
    n_checks++; if ({kv0, kh0} !== 2'b11) begin n_fail++;
      $display("FAIL mrst_pre got v=%b h=%b exp 1 1", kv0, kh0); end
    rst_n = 1'b0;
    #2;
    n_checks++; if (col0 !== 4'hF) begin n_fail++; $display("FAIL mrst_col got %h exp f", col0); end
    n_checks++; if ({kc0, kv0, kh0, mk0, ov0} !== 8'h00) begin n_fail++;
      $display("FAIL mrst_outs got code=%0d v=%b h=%b m=%b o=%b exp all 0", kc0, kv0, kh0, mk0, ov0); end
    wait_cyc(3);
    base = codes0.size();
    kr0 = 1'b1;
    rst_n = 1'b1;
    wait_cyc(100);
    n_checks++; if (kh0 !== 1'b1) begin n_fail++; $display("FAIL mrst_reheld got %b exp 1", kh0); end
    n_checks++; if (codes0.size() - base !== 1) begin n_fail++;
      $display("FAIL mrst_count got %0d exp 1", codes0.size() - base); end
    else begin
      n_checks++; if (codes0[base] !== 6) begin n_fail++; $display("FAIL mrst_code got %0d exp 6", codes0[base]); end
    end
    keys0 = 16'h0;
    wait_cyc(100);
    n_checks++; if (kh0 !== 1'b0) begin n_fail++; $display("FAIL mrst_release got %b exp 0", kh0); end
  endtask

  initial begin
    test_reset();
    test_each_key();
    test_bounce();
    test_multi_key();
    test_repeat();
    test_overrun();
    test_mid_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
